serial_mux_sched: RTL and testbench

SERIAL_MUX_SCHED -- requirements
Module: serial_mux_sched

---
 rtl/serial_mux_sched.sv | 125 ++++++++++++
 tb/tb_serial_mux_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_mux_sched.sv
// Round-robin 4:1 byte scheduler onto a single serial line: start bit, two port bits,
// eight data bits MSB first, and a stop slot that can chain further bytes of the same burst.
module serial_mux_sched #(
    parameter int MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  ack,
    output logic        se_out,
    output logic [1:0]  cur_port,
    output logic        busy
);
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_P1,
        S_P0,
        S_DATA,
        S_STOP
    } state_t;

    state_t     state_q;
    logic [1:0] cur_port_q;
    logic [1:0] last_grant_q;
    logic [7:0] shreg_q;
    logic [2:0] bitcnt_q;
    logic [3:0] burst_q;

    logic [1:0] win_d;
    logic       grant_d;
    logic       cont_d;

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // ack is combinational so that it coincides with the cycle whose data_in is captured
    always_comb begin
        win_d   = rr_pick(req, last_grant_q);
        grant_d = !reset && (state_q == S_IDLE) && (req != '0);
        cont_d  = !reset && (state_q == S_STOP) && req[cur_port_q] && (burst_q < MAX_B);
        ack     = '0;
        if (grant_d) begin
            ack[win_d] = 1'b1;
        end else if (cont_d) begin
            ack[cur_port_q] = 1'b1;
        end
        case (state_q)
            S_IDLE:  se_out = 1'b1;
            S_START: se_out = 1'b0;
            S_P1:    se_out = cur_port_q[1];
            S_P0:    se_out = cur_port_q[0];
            S_DATA:  se_out = shreg_q[7];
            S_STOP:  se_out = !cont_d;
            default: se_out = 1'b1;
        endcase
    end

    assign cur_port = cur_port_q;
    assign busy     = (state_q != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_port_q   <= '0;
            last_grant_q <= 2'd3;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            burst_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_d) begin
                        shreg_q      <= data_in[{win_d, 3'b000} +: 8];
                        cur_port_q   <= win_d;
                        last_grant_q <= win_d;
                        burst_q      <= 4'd1;
                        state_q      <= S_START;
                    end
                end
                S_START: state_q <= S_P1;
                S_P1:    state_q <= S_P0;
                S_P0: begin
                    bitcnt_q <= '0;
                    state_q  <= S_DATA;
                end
                S_DATA: begin
                    shreg_q  <= {shreg_q[6:0], 1'b0};
                    bitcnt_q <= bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    // a continued byte skips start and port bits
                    if (cont_d) begin
                        shreg_q  <= data_in[{cur_port_q, 3'b000} +: 8];
                        burst_q  <= (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
                        bitcnt_q <= '0;
                        state_q  <= S_DATA;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mux_sched.sv
// Randomized scoreboard bench for serial_mux_sched: a frame-level model queues the
// expected line/ack/busy/port per cycle, a monitor pops and compares on the falling edge.
module tb_serial_mux_sched;
    localparam int MB = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic        se_out;
    logic [1:0]  cur_port;
    logic        busy;

    serial_mux_sched #(.MAX_BURST(MB)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .se_out   (se_out),
        .cur_port (cur_port),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] ack;
        logic       se;
        logic       busy;
        logic [1:0] cp;
    } exp_t;

    exp_t exp_q[$];
    logic se_log[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_push = 0;

    // model state: a frame is a queue of line bits still to send; empty queue while busy = stop slot
    logic       m_busy;
    logic       bitq[$];
    logic [1:0] m_port;
    logic [1:0] m_last;
    int         m_burst;

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) bitq.push_back(b[k]);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        bitq.delete();
        m_port  = 2'd0;
        m_last  = 2'd3;
        m_burst = 0;
    endtask

    task automatic model_step(input logic rst, input logic [3:0] r, input logic [31:0] d);
        exp_t       e;
        logic [3:0] reff;
        int         w;
        logic [1:0] wl;
        reff   = rst ? 4'b0000 : r;
        e.busy = m_busy;
        e.cp   = m_port;
        e.ack  = 4'b0000;
        e.se   = 1'b1;
        if (!m_busy) begin
            if (reff != 4'b0000) begin
                w = -1;
                for (int k = 1; k <= 4; k++)
                    if (w < 0 && reff[(int'(m_last) + k) % 4]) w = (int'(m_last) + k) % 4;
                wl    = 2'(w);
                e.ack = 4'b0001 << w;
                bitq.delete();
                bitq.push_back(1'b0);
                bitq.push_back(wl[1]);
                bitq.push_back(wl[0]);
                push_byte(d[8*w +: 8]);
                m_port  = wl;
                m_last  = wl;
                m_burst = 1;
                m_busy  = 1'b1;
            end
        end else if (bitq.size() > 0) begin
            e.se = bitq.pop_front();
        end else if (reff[m_port] && m_burst < MB) begin
            e.se  = 1'b0;
            e.ack = 4'b0001 << m_port;
            m_burst++;
            push_byte(d[8*int'(m_port) +: 8]);
        end else begin
            e.se   = 1'b1;
            m_busy = 1'b0;
        end
        exp_q.push_back(e);
        n_push++;
        if (rst) model_reset();
    endtask

    task automatic cycle(input logic rst, input logic [3:0] r, input logic [31:0] d);
        @(posedge clock);
        #1;
        reset   = rst;
        req     = r;
        data_in = d;
        model_step(rst, r, d);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                se_log.push_back(se_out);
                n_cmp++;
                if (ack !== e.ack || se_out !== e.se || busy !== e.busy || cur_port !== e.cp) begin
                    n_fail++;
                    $display("FAIL cycle%0d t=%0t: ack=%b se=%b busy=%b port=%0d, required ack=%b se=%b busy=%b port=%0d",
                             se_log.size() - 1, $time, ack, se_out, busy, cur_port, e.ack, e.se, e.busy, e.cp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          mark;
        logic [11:0] pat;
        logic [3:0]  r;
        logic        ok;
        reset   = 1'b1;
        req     = 4'b0000;
        data_in = 32'h0;
        repeat (2) @(posedge clock);
        model_reset();
        cycle(1'b1, 4'b0000, 32'h0);
        cycle(1'b1, 4'b1111, 32'h12345678);
        repeat (3) cycle(1'b0, 4'b0000, $urandom);

        // single byte A5 from port 2
        mark = n_push;
        cycle(1'b0, 4'b0100, 32'h00A50000);
        repeat (15) cycle(1'b0, 4'b0000, $urandom);

        // all requesters held from reset: bursts rotate 0,1,2,3,0
        cycle(1'b1, 4'b0000, 32'h0);
        for (int i = 0; i < 215; i++) cycle(1'b0, 4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hA0} ^ (i << 3));
        repeat (15) cycle(1'b0, 4'b0000, $urandom);

        // port 1 wants six bytes, burst caps at four then re-arbitrates
        for (int i = 0; i < 70; i++) cycle(1'b0, (i < 60) ? 4'b0010 : 4'b0000, $urandom);

        // port 0 drops during its second byte
        for (int i = 0; i < 30; i++) cycle(1'b0, (i < 16) ? 4'b0001 : 4'b0000, $urandom);

        // reset in the middle of data bit 4, then only port 3 requests
        cycle(1'b0, 4'b0001, $urandom);
        for (int i = 1; i < 8; i++) cycle(1'b0, 4'b0000, $urandom);
        cycle(1'b1, 4'b1000, $urandom);
        repeat (20) cycle(1'b0, 4'b1000, $urandom);
        repeat (20) cycle(1'b0, 4'b0000, $urandom);

        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) r = 4'($urandom);
            if ($urandom_range(40) == 0) r = 4'b0000;
            cycle($urandom_range(299) == 0, r, $urandom);
        end
        repeat (20) cycle(1'b0, 4'b0000, $urandom);
        repeat (3) @(negedge clock);
        #1;

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        // line bits of the A5 frame, start bit through the stop slot
        pat = 12'b0101_0100_1011;
        ok  = 1'b1;
        for (int i = 0; i < 12; i++)
            if (se_log.size() <= mark + 1 + i || se_log[mark + 1 + i] !== pat[11 - i]) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL a5_frame: observed line differs from required %b", pat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
